// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on a req/gnt/rvalid bus, extracts load lanes, stalls upstream.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        memtoreg_in,
    input  logic        regwrite_en_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] aluresult_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  write_address_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        memtoreg_out,
    output logic        regwrite_en_out,
    output logic [31:0] read_data_out,
    output logic [31:0] aluresult_out,
    output logic [4:0]  write_address_out,
    output logic        bus_err,
    output logic        misalign_err
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        DONE     = 2'd2,
        ERR      = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [31:0]       rdata_q, rdata_next;

    logic              mem_op;
    logic [1:0]        byte_off;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic              misaligned;

    assign mem_op   = mem_read_in | mem_write_in;
    assign byte_off = aluresult_in[1:0];

    // Sign/zero-extended lane selection for the captured load word.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    // Byte enables and replicated write data; stores treat only SB/SH as sub-word.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = store_data_in;
        if (mem_write_in) begin
            case (funct3_in)
                3'b000: begin
                    lane_be    = 4'b0001 << byte_off;
                    lane_wdata = {4{store_data_in[7:0]}};
                end
                3'b001: begin
                    lane_be    = byte_off[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{store_data_in[15:0]}};
                end
                default: lane_be = 4'b1111;
            endcase
        end else begin
            case (funct3_in[1:0])
                2'b00:   lane_be = 4'b0001 << byte_off;
                2'b01:   lane_be = byte_off[1] ? 4'b1100 : 4'b0011;
                default: lane_be = 4'b1111;
            endcase
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        if (mem_write_in)
            misaligned = ((funct3_in == 3'b010) && (byte_off != 2'b00)) ||
                         ((funct3_in == 3'b001) && byte_off[0]);
        else
            misaligned = ((funct3_in == 3'b010) && (byte_off != 2'b00)) ||
                         ((funct3_in[1:0] == 2'b01) && byte_off[0]);
    end
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            rdata_q <= rdata_next;
        end
    end

    // Next state, timeout counter and all stage outputs; everything reads 0 under reset.
    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        rdata_next        = rdata_q;
        dmem_req          = 1'b0;
        dmem_we           = 1'b0;
        dmem_addr         = '0;
        dmem_be           = '0;
        dmem_wdata        = '0;
        stall_out         = 1'b0;
        memtoreg_out      = 1'b0;
        regwrite_en_out   = 1'b0;
        read_data_out     = '0;
        aluresult_out     = '0;
        write_address_out = '0;
        bus_err           = 1'b0;
        misalign_err      = 1'b0;

        if (!reset) begin
            memtoreg_out      = memtoreg_in;
            regwrite_en_out   = regwrite_en_in;
            aluresult_out     = aluresult_in;
            write_address_out = write_address_in;

            case (state)
                IDLE: begin
                    if (mem_op && misaligned) begin
                        misalign_err    = 1'b1;
                        regwrite_en_out = 1'b0;
                    end else if (mem_op) begin
                        dmem_req        = 1'b1;
                        dmem_we         = mem_write_in;
                        dmem_addr       = {aluresult_in[31:2], 2'b00};
                        dmem_be         = lane_be;
                        dmem_wdata      = mem_write_in ? lane_wdata : 32'h0;
                        stall_out       = 1'b1;
                        regwrite_en_out = 1'b0;
                        if (dmem_gnt) begin
                            cnt_next = '0;
                            if (mem_write_in) begin
                                stall_out       = 1'b0;
                                regwrite_en_out = regwrite_en_in;
                            end else begin
                                state_next = WAIT_RSP;
                            end
                        end else if (cnt == CNT_LAST) begin
                            state_next = ERR;
                        end else begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end
                end
                WAIT_RSP: begin
                    stall_out       = 1'b1;
                    regwrite_en_out = 1'b0;
                    if (dmem_rvalid) begin
                        rdata_next = dmem_rdata;
                        state_next = DONE;
                    end else if (cnt == CNT_LAST) begin
                        state_next = ERR;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    read_data_out = load_extract(rdata_q, byte_off, funct3_in);
                    state_next    = IDLE;
                end
                ERR: begin
                    bus_err         = 1'b1;
                    regwrite_en_out = 1'b0;
                    state_next      = IDLE;
                end
                default: state_next = IDLE;
            endcase

            if (state_next != state)
                cnt_next = '0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT_CYCLES = 4).
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_in, mem_write_in, memtoreg_in, regwrite_en_in;
    logic [2:0]  funct3_in;
    logic [31:0] aluresult_in, store_data_in;
    logic [4:0]  write_address_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_out, memtoreg_out, regwrite_en_out;
    logic [31:0] read_data_out, aluresult_out;
    logic [4:0]  write_address_out;
    logic        bus_err, misalign_err;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .memtoreg_in(memtoreg_in), .regwrite_en_in(regwrite_en_in),
        .funct3_in(funct3_in), .aluresult_in(aluresult_in),
        .store_data_in(store_data_in), .write_address_in(write_address_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall_out(stall_out), .memtoreg_out(memtoreg_out),
        .regwrite_en_out(regwrite_en_out), .read_data_out(read_data_out),
        .aluresult_out(aluresult_out), .write_address_out(write_address_out),
        .bus_err(bus_err), .misalign_err(misalign_err)
    );

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_nop();
        mem_read_in = 0; mem_write_in = 0; memtoreg_in = 0; regwrite_en_in = 1;
        funct3_in = 3'b000; aluresult_in = 32'h1234; store_data_in = 32'h0;
        write_address_in = 5'd5; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1; set_nop();
        step(); step(); #1;
        vecs++;
        if ({dmem_req, dmem_we, dmem_be, stall_out, memtoreg_out, regwrite_en_out,
             bus_err, misalign_err, aluresult_out, write_address_out, read_data_out} !== '0) begin
            $display("FAIL reset_outputs: req=%b be=%b stall=%b rw=%b alu=%h rd=%0d", dmem_req,
                     dmem_be, stall_out, regwrite_en_out, aluresult_out, write_address_out);
            errs++;
        end
        reset = 0;
    endtask

    task automatic test_passthrough();
        step(); set_nop(); dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF; #1;
        vecs++;
        if ({stall_out, dmem_req, regwrite_en_out, memtoreg_out} !== 4'b0010 ||
            aluresult_out !== 32'h1234 || write_address_out !== 5'd5 || read_data_out !== 32'h0) begin
            $display("FAIL passthrough: stall=%b req=%b rw=%b alu=%h rd=%0d data=%h exp 0/0/1 1234 5 0",
                     stall_out, dmem_req, regwrite_en_out, aluresult_out, write_address_out, read_data_out);
            errs++;
        end
        dmem_rvalid = 0;
    endtask

    task automatic test_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                              input int gnt_dly, input logic [3:0] exp_be, input logic [31:0] exp_wd);
        for (int i = 0; i <= gnt_dly; i++) begin
            step();
            mem_write_in = 1; mem_read_in = 0; regwrite_en_in = 0; memtoreg_in = 0;
            funct3_in = f3; aluresult_in = addr; store_data_in = data; dmem_gnt = (i == gnt_dly);
            #1;
            vecs++;
            if ({dmem_req, dmem_we, stall_out} !== {2'b11, (i != gnt_dly)} || dmem_be !== exp_be ||
                dmem_wdata !== exp_wd || dmem_addr !== {addr[31:2], 2'b00}) begin
                $display("FAIL store_cyc%0d: req=%b we=%b stall=%b be=%b wd=%h addr=%h exp be=%b wd=%h",
                         i, dmem_req, dmem_we, stall_out, dmem_be, dmem_wdata, dmem_addr, exp_be, exp_wd);
                errs++;
            end
        end
        step(); set_nop(); #1;
        vecs++;
        if ({dmem_req, stall_out, regwrite_en_out} !== 3'b001) begin
            $display("FAIL store_after: req=%b stall=%b rw=%b exp 0 0 1", dmem_req, stall_out, regwrite_en_out);
            errs++;
        end
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                             input int gnt_dly, input int rsp_dly, input logic [3:0] exp_be,
                             input logic [31:0] exp_data);
        for (int i = 0; i <= gnt_dly; i++) begin
            step();
            mem_read_in = 1; mem_write_in = 0; regwrite_en_in = 1; memtoreg_in = 1;
            funct3_in = f3; aluresult_in = addr; write_address_in = 5'd7; dmem_gnt = (i == gnt_dly);
            #1;
            vecs++;
            if ({dmem_req, dmem_we, stall_out, regwrite_en_out} !== 4'b1010 || dmem_be !== exp_be ||
                dmem_addr !== {addr[31:2], 2'b00}) begin
                $display("FAIL load_req%0d: req=%b we=%b stall=%b rw=%b be=%b addr=%h exp be=%b",
                         i, dmem_req, dmem_we, stall_out, regwrite_en_out, dmem_be, dmem_addr, exp_be);
                errs++;
            end
        end
        for (int i = 1; i <= rsp_dly; i++) begin
            step(); dmem_gnt = 0;
            dmem_rvalid = (i == rsp_dly); dmem_rdata = (i == rsp_dly) ? rdata : 32'h5A5A_5A5A;
            #1;
            vecs++;
            if ({dmem_req, stall_out, regwrite_en_out} !== 3'b010 || read_data_out !== 32'h0) begin
                $display("FAIL load_wait%0d: req=%b stall=%b rw=%b data=%h exp 0 1 0 0",
                         i, dmem_req, stall_out, regwrite_en_out, read_data_out);
                errs++;
            end
        end
        step(); dmem_rvalid = 0; dmem_rdata = 32'h0; #1;
        vecs++;
        if ({stall_out, regwrite_en_out, memtoreg_out, dmem_req} !== 4'b0110 ||
            read_data_out !== exp_data || write_address_out !== 5'd7) begin
            $display("FAIL load_done: stall=%b rw=%b m2r=%b data=%h exp %h", stall_out,
                     regwrite_en_out, memtoreg_out, read_data_out, exp_data);
            errs++;
        end
        step(); set_nop(); #1;
        vecs++;
        if ({stall_out, dmem_req} !== 2'b00 || read_data_out !== 32'h0) begin
            $display("FAIL load_after: stall=%b req=%b data=%h", stall_out, dmem_req, read_data_out);
            errs++;
        end
    endtask

    // Load granted but never answered, then a store never granted: both end in one ERR cycle.
    task automatic test_timeout();
        step(); mem_read_in = 1; regwrite_en_in = 1; funct3_in = 3'b010; aluresult_in = 32'h200;
        dmem_gnt = 1; #1;
        for (int i = 1; i <= 4; i++) begin
            step(); dmem_gnt = 0; #1;
            vecs++;
            if ({stall_out, bus_err} !== 2'b10) begin
                $display("FAIL ld_timeout_wait%0d: stall=%b bus_err=%b exp 1 0", i, stall_out, bus_err);
                errs++;
            end
        end
        step(); #1;
        vecs++;
        if ({bus_err, stall_out, regwrite_en_out, dmem_req} !== 4'b1000 || read_data_out !== 32'h0) begin
            $display("FAIL ld_timeout_err: bus_err=%b stall=%b rw=%b req=%b data=%h exp 1 0 0 0 0",
                     bus_err, stall_out, regwrite_en_out, dmem_req, read_data_out);
            errs++;
        end
        step(); set_nop(); #1;
        vecs++;
        if ({bus_err, stall_out} !== 2'b00) begin
            $display("FAIL ld_timeout_after: bus_err=%b stall=%b exp 0 0", bus_err, stall_out);
            errs++;
        end
        for (int i = 0; i < 4; i++) begin
            step(); mem_write_in = 1; regwrite_en_in = 0; funct3_in = 3'b010; aluresult_in = 32'h300; #1;
            vecs++;
            if ({stall_out, dmem_req, bus_err} !== 3'b110) begin
                $display("FAIL st_timeout_wait%0d: stall=%b req=%b bus_err=%b exp 1 1 0",
                         i, stall_out, dmem_req, bus_err);
                errs++;
            end
        end
        step(); #1;
        vecs++;
        if ({bus_err, stall_out, dmem_req} !== 3'b100) begin
            $display("FAIL st_timeout_err: bus_err=%b stall=%b req=%b exp 1 0 0", bus_err, stall_out, dmem_req);
            errs++;
        end
        step(); set_nop(); #1;
    endtask

    task automatic test_reset_midop();
        step(); mem_read_in = 1; regwrite_en_in = 1; memtoreg_in = 1; funct3_in = 3'b010;
        aluresult_in = 32'h400; write_address_in = 5'd9; dmem_gnt = 1; #1;
        step(); dmem_gnt = 0; #1;
        step(); reset = 1; #1;
        vecs++;
        if ({dmem_req, dmem_we, dmem_be, stall_out, memtoreg_out, regwrite_en_out, bus_err,
             misalign_err, aluresult_out, write_address_out, read_data_out, dmem_addr} !== '0) begin
            $display("FAIL reset_midop: req=%b stall=%b rw=%b alu=%h rd=%0d addr=%h exp all 0",
                     dmem_req, stall_out, regwrite_en_out, aluresult_out, write_address_out, dmem_addr);
            errs++;
        end
        step(); reset = 0; set_nop(); dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF; #1;
        vecs++;
        if ({stall_out, regwrite_en_out} !== 2'b01 || read_data_out !== 32'h0 || aluresult_out !== 32'h1234) begin
            $display("FAIL reset_rvalid_ignored: stall=%b rw=%b data=%h alu=%h exp 0 1 0 1234",
                     stall_out, regwrite_en_out, read_data_out, aluresult_out);
            errs++;
        end
        step(); set_nop(); #1;
        vecs++;
        if ({stall_out, read_data_out} !== 33'h0) begin
            $display("FAIL reset_next_idle: stall=%b data=%h exp 0 0", stall_out, read_data_out);
            errs++;
        end
        test_store(3'b010, 32'h404, 32'h1122_3344, 0, 4'b1111, 32'h1122_3344);
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_CHECK_EN
        step(); mem_read_in = 1; regwrite_en_in = 1; funct3_in = 3'b010; aluresult_in = 32'h102; #1;
        vecs++;
        if ({misalign_err, dmem_req, stall_out, regwrite_en_out} !== 4'b1000) begin
            $display("FAIL misalign_lw: err=%b req=%b stall=%b rw=%b exp 1 0 0 0",
                     misalign_err, dmem_req, stall_out, regwrite_en_out);
            errs++;
        end
        step(); set_nop(); mem_write_in = 1; regwrite_en_in = 0; funct3_in = 3'b001;
        aluresult_in = 32'h101; #1;
        vecs++;
        if ({misalign_err, dmem_req, stall_out} !== 3'b100) begin
            $display("FAIL misalign_sh: err=%b req=%b stall=%b exp 1 0 0", misalign_err, dmem_req, stall_out);
            errs++;
        end
        step(); set_nop(); #1;
        vecs++;
        if (misalign_err !== 1'b0) begin
            $display("FAIL misalign_clear: err=%b exp 0", misalign_err);
            errs++;
        end
`else
        test_load(3'b010, 32'h102, 32'hCAFE_F00D, 0, 1, 4'b1111, 32'hCAFE_F00D);
        vecs++;
        if (misalign_err !== 1'b0) begin
            $display("FAIL misalign_tied: err=%b exp 0", misalign_err);
            errs++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_store(3'b000, 32'h103, 32'h0000_00AB, 0, 4'b1000, 32'hABAB_ABAB);
        test_store(3'b001, 32'h102, 32'h1234_ABCD, 2, 4'b1100, 32'hABCD_ABCD);
        test_load(3'b000, 32'h102, 32'h0080_0000, 0, 3, 4'b0100, 32'hFFFF_FF80);
        test_load(3'b100, 32'h102, 32'h0080_0000, 0, 3, 4'b0100, 32'h0000_0080);
        test_load(3'b001, 32'h102, 32'h8001_0000, 1, 1, 4'b1100, 32'hFFFF_8001);
        test_load(3'b101, 32'h100, 32'h1234_8765, 0, 2, 4'b0011, 32'h0000_8765);
        test_load(3'b010, 32'h104, 32'hDEAD_BEEF, 0, 1, 4'b1111, 32'hDEAD_BEEF);
        test_timeout();
        test_reset_midop();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
